axi_lite_master: RTL
====================

# axi_lite_master

AXI4-Lite initiator for the zed_io fabric. It accepts one single-beat read or write command at a time on a simple valid/ready command port and runs the matching AXI4-Lite transaction against a slave such as the GPIO block. It returns read data and response code on a one-cycle response strobe. A programmable timeout aborts a transaction if the slave stalls, so a hung peripheral cannot lock up the controlling logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; WSTRB width is DATA_W/8
- TIMEOUT, 255, cycle limit from command accept to response before abort; minimum 4
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  reset; asynchronous assertion, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  byte strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  transaction aborted by timeout
- AWVALID/AWREADY/AWADDR(ADDR_W)/AWPROT(3), WVALID/WREADY/WDATA(DATA_W)/WSTRB, BVALID/BREADY/BRESP(2), ARVALID/ARREADY/ARADDR(ADDR_W)/ARPROT(3), RVALID/RREADY/RDATA(DATA_W)/RRESP(2): standard AXI4-Lite master side; valids and readies out, slave signals in

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: cmd_ready=1. On cmd_valid at an edge, latch addr/wdata/wstrb/write.
  - If write, go to WR_REQ; if read, go to RD_REQ.
  - Clear the timeout counter.
- WR_REQ:
  - AWVALID and WVALID rise together.
  - Each valid drops on the edge of its own handshake (VALID&&READY). The two channels complete independently, in either order or together.
  - When both channels have completed, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_REQ: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA and RRESP and go to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_* hold their captured values until the next DONE.
  - Return to IDLE.
- All AXI outputs and rsp_* are registered; there is no combinational path from slave inputs to master outputs.
- AWADDR/ARADDR/WDATA/WSTRB are driven from the latched command and stay stable while the corresponding valid is high. They are 0 when idle.
- AWPROT = ARPROT = 3'b000 constant.
- Timeout:
  - The counter increments every cycle outside IDLE/DONE.
  - When it reaches TIMEOUT-1 without completion, all VALID/READY outputs drop at the next edge and the FSM goes to DONE with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - A handshake occurring on that same edge wins; the transaction completes normally.
- cmd_valid outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: cmd_ready=1 after reset release; all VALID/READY outputs=0, addresses/data=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0; state IDLE.
- Command accepted at edge 0 → request valid(s) high after edge 0.
- With a zero-wait slave (READY high, response one cycle later):
  - Write: AW+W handshake at edge 1, B handshake at edge 2, rsp_valid high between edges 2 and 3, cmd_ready high after edge 3. Minimum write cost is 4 cycles command-to-command.
  - Read: the same timing applies with AR and R in place of AW/W and B.
- Reset mid-transaction: all outputs go to their reset values asynchronously, with no rsp_valid pulse. The transaction is discarded.
- Timeout is measured from edge 0. rsp_valid is high during cycle TIMEOUT+1 at the latest.

## Test plan
- Write 32'h000000AA, wstrb 4'h1, addr 0, zero-wait slave → AWADDR=0, WDATA=0xAA one cycle after accept; rsp_valid 3 cycles after accept; rsp_resp=00; rsp_timeout=0.
- Write with the slave holding WREADY low 3 cycles after AWREADY → AWVALID drops after its handshake, WVALID stays high 3 more cycles; BREADY rises only after both handshakes; exactly one rsp_valid.
- Read addr 8, RVALID delayed 5 cycles with RDATA=32'h00000055 → RREADY held high throughout; rsp_rdata=0x55; rsp_resp=00.
- Write addr 4, slave returns BRESP=2'b10 → rsp_resp=10, rsp_timeout=0.
- TIMEOUT=16, slave never asserts ARREADY → ARVALID drops 16 cycles after accept; rsp_valid with rsp_resp=10, rsp_timeout=1, rsp_rdata=0; the next command is accepted normally.
- ARESETn low during RD_RESP → RREADY=0 and cmd_ready=0 immediately, no rsp_valid; after release cmd_ready=1 and a new read completes.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-beat AXI4-Lite initiator: one command at a time, registered AXI/rsp outputs, timeout abort.
// Zero-wait slave: response strobe two edges after accept; new commands are refused (cmd_ready=0) until back in IDLE.
module axi_lite_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_tmo_q, rsp_tmo_d;

  logic expired;
  logic timeout_hit;
  logic aw_ok;
  logic w_ok;
  logic busy;

  assign expired = (cnt_q >= LIMIT);
  // A write channel counts as finished once its valid has dropped or handshakes this edge.
  assign aw_ok   = !awvalid_q || AWREADY;
  assign w_ok    = !wvalid_q || WREADY;
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; any handshake that advances the FSM takes priority over the timeout
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = cmd_write ? S_WR_REQ : S_RD_REQ;
      end
      S_WR_REQ: begin
        if (aw_ok && w_ok) begin
          state_d = S_WR_RESP;
        end else if (expired) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (BVALID) begin
          state_d = S_DONE;
        end else if (expired) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (ARREADY) begin
          state_d = S_RD_RESP;
        end else if (expired) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_RD_RESP: begin
        if (RVALID) begin
          state_d = S_DONE;
        end else if (expired) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Saturating at the limit keeps later phases expired without wrapping.
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (busy && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output next-state values
  always_comb begin
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_tmo_d   = rsp_tmo_q;
    rsp_valid_d = (state_d == S_DONE) && (state_q != S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end
      S_WR_REQ: begin
        if (AWREADY || timeout_hit) awvalid_d = 1'b0;
        if (WREADY || timeout_hit)  wvalid_d  = 1'b0;
        if (state_d == S_WR_RESP)   bready_d  = 1'b1;
      end
      S_WR_RESP: begin
        if (state_d == S_DONE) bready_d = 1'b0;
        if (BVALID) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = BRESP;
          rsp_tmo_d   = 1'b0;
        end
      end
      S_RD_REQ: begin
        if (state_d != S_RD_REQ)  arvalid_d = 1'b0;
        if (state_d == S_RD_RESP) rready_d  = 1'b1;
      end
      S_RD_RESP: begin
        if (state_d == S_DONE) rready_d = 1'b0;
        if (RVALID) begin
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rsp_tmo_d   = 1'b0;
        end
      end
      S_DONE: begin
        awaddr_d = '0;
        araddr_d = '0;
        wdata_d  = '0;
        wstrb_d  = '0;
      end
      default: ;
    endcase

    if (timeout_hit) begin
      rsp_rdata_d = '0;
      rsp_resp_d  = 2'b10;
      rsp_tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_tmo_q   <= 1'b0;
    end else begin
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  // Gated by reset so the port reads 0 while ARESETn is held low.
  assign cmd_ready   = ARESETn && (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_tmo_q;
  assign AWVALID     = awvalid_q;
  assign AWADDR      = awaddr_q;
  assign AWPROT      = 3'b000;
  assign WVALID      = wvalid_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign BREADY      = bready_q;
  assign ARVALID     = arvalid_q;
  assign ARADDR      = araddr_q;
  assign ARPROT      = 3'b000;
  assign RREADY      = rready_q;

endmodule
